// File: rtl/hex_keypad_entry_if.sv
// Keypad pins plus the entered-value outputs of hex_keypad_entry.
// master = the scanner, slave = the board/consumer side.
interface hex_keypad_entry_if;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] data;
    logic [3:0]  key_code;
    logic        key_valid;

    modport master (
        input  col,
        output row,
        output data,
        output key_code,
        output key_valid
    );

    modport slave (
        output col,
        input  row,
        input  data,
        input  key_code,
        input  key_valid
    );
endinterface

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce and 16-bit digit shift register.
// Define KEYPAD_SYNC_EN to add a 2-flop synchronizer on the col inputs.
module hex_keypad_entry #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 8
) (
    input logic               clk,
    input logic               reset,
    hex_keypad_entry_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       row_q, row_d;
    logic [3:0]       code_q, code_d;
    logic [3:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rel_q, rel_d;
    logic [15:0]      data_q, data_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;

    logic [3:0]       col_s;
    logic             tick;
    logic             col_valid;
    logic [1:0]       col_idx;
    logic [1:0]       row_idx;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rel_inc;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = kp.col;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign col_s = sync2_q;
`else
    assign col_s = kp.col;
`endif

    assign tick    = (div_q == DIV_MAX);
    assign cnt_inc = cnt_q + 1'b1;
    assign rel_inc = rel_q + 1'b1;

    // Exactly one low column is a key; anything else counts as no key.
    always_comb begin
        col_valid = 1'b1;
        col_idx   = 2'd0;
        case (col_s)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_valid = 1'b0;
        endcase
    end

    always_comb begin
        row_idx = 2'd0;
        case (row_q)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        row_d       = row_q;
        code_d      = code_q;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        data_d      = data_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (col_valid) begin
                        code_d  = {row_idx, col_idx};
                        pat_d   = col_s;
                        cnt_d   = CNT_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = {row_q[2:0], row_q[3]};
                    end
                end
                DEBOUNCE: begin
                    if (col_s == pat_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            data_d      = {data_q[11:0], code_q};
                            key_code_d  = code_q;
                            key_valid_d = 1'b1;
                            rel_d       = '0;
                            state_d     = HELD;
                        end
                    end else begin
                        // Same row gets re-evaluated on the next tick.
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (col_s == 4'hF) begin
                        rel_d = rel_inc;
                        if (rel_inc == CNT_MAX) begin
                            rel_d   = '0;
                            row_d   = {row_q[2:0], row_q[3]};
                            state_d = SCAN;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            div_q       <= '0;
            row_q       <= 4'b1110;
            code_q      <= 4'h0;
            pat_q       <= 4'hF;
            cnt_q       <= '0;
            rel_q       <= '0;
            data_q      <= 16'h0000;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            row_q       <= row_d;
            code_q      <= code_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            data_q      <= data_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign kp.row       = row_q;
    assign kp.data      = data_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with SCAN_DIV=4, DEBOUNCE_TICKS=3.
module tb_hex_keypad_entry;

    localparam int S = 4;
    localparam int D = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    hex_keypad_entry_if kif ();

    hex_keypad_entry #(
        .SCAN_DIV      (S),
        .DEBOUNCE_TICKS(D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kif)
    );

    always #5 clk = ~clk;

    int pass_n = 0;
    int tot_n  = 0;
    int pulses = 0;
    int tb_div = 0;

    logic       key_on  = 1'b0;
    logic [1:0] key_r   = 2'd0;
    logic [1:0] key_c   = 2'd0;
    logic       frc_en  = 1'b0;
    logic [3:0] frc_val = 4'hF;
    logic       dual_en = 1'b0;
    logic [3:0] col_m;

    // Board model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_m = 4'hF;
        if (frc_en)
            col_m = frc_val;
        else if (dual_en)
            col_m = (kif.row == 4'b1101) ? 4'b1100 : 4'hF;
        else if (key_on && kif.row == ~(4'b0001 << key_r))
            col_m = ~(4'b0001 << key_c);
    end
    assign kif.col = col_m;

    always @(posedge clk) begin
        if (reset) tb_div <= 0;
        else tb_div <= (tb_div == S - 1) ? 0 : tb_div + 1;
    end

    always @(negedge clk) if (kif.key_valid === 1'b1) pulses++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * S) step();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        tot_n++; if (kif.row !== 4'b1110) $display("FAIL reset_row: got %b want 1110", kif.row); else pass_n++;
        tot_n++; if (kif.data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", kif.data); else pass_n++;
        tot_n++; if (kif.key_code !== 4'h0) $display("FAIL reset_code: got %h want 0", kif.key_code); else pass_n++;
        tot_n++; if (kif.key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", kif.key_valid); else pass_n++;
        reset = 1'b0;
    endtask

    task automatic test_idle;
        logic [3:0] rots [4];
        rots = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 40; i++) begin
            tot_n++;
            if (kif.row !== rots[(i / 4) % 4])
                $display("FAIL idle_row c%0d: got %b want %b", i, kif.row, rots[(i / 4) % 4]);
            else pass_n++;
            tot_n++;
            if (kif.key_valid !== 1'b0) $display("FAIL idle_valid c%0d: got 1 want 0", i); else pass_n++;
            step();
        end
        tot_n++; if (kif.data !== 16'h0000) $display("FAIL idle_data: got %h want 0000", kif.data); else pass_n++;
        tot_n++; if (pulses !== 0) $display("FAIL idle_pulses: got %0d want 0", pulses); else pass_n++;
    endtask

    task automatic test_hold_key9;
        int det = -1;
        int hit = -1;
        int p0 = pulses;
        key_r = 2'd2; key_c = 2'd1; key_on = 1'b1;
        for (int n = 0; n < 80; n++) begin
            if (det < 0 && tb_div == S - 1 && kif.row == 4'b1011) det = n;
            if (kif.key_valid === 1'b1 && hit < 0) begin
                hit = n;
                tot_n++; if (kif.key_code !== 4'h9) $display("FAIL k9_code: got %h want 9", kif.key_code); else pass_n++;
                tot_n++; if (kif.data !== 16'h0009) $display("FAIL k9_data: got %h want 0009", kif.data); else pass_n++;
            end
            step();
        end
        tot_n++; if (hit - det !== 9) $display("FAIL k9_latency: got %0d want 9", hit - det); else pass_n++;
        tot_n++; if (pulses - p0 !== 1) $display("FAIL k9_pulses: got %0d want 1", pulses - p0); else pass_n++;
        tot_n++; if (kif.row !== 4'b1011) $display("FAIL k9_row_held: got %b want 1011", kif.row); else pass_n++;
        key_on = 1'b0;
        for (int n = 0; n < 40 && kif.row == 4'b1011; n++) step();
        tot_n++; if (kif.row !== 4'b0111) $display("FAIL k9_row_after: got %b want 0111", kif.row); else pass_n++;
    endtask

    task automatic press_key(input logic [1:0] r, input logic [1:0] c,
                             input logic [15:0] exp_data);
        bit hit = 1'b0;
        int p0 = pulses;
        key_r = r; key_c = c; key_on = 1'b1;
        for (int n = 0; n < 200 && !hit; n++) begin
            if (kif.key_valid === 1'b1) begin
                hit = 1'b1;
                tot_n++;
                if (kif.key_code !== {r, c}) $display("FAIL key_code: got %h want %h", kif.key_code, {r, c}); else pass_n++;
                tot_n++;
                if (kif.data !== exp_data) $display("FAIL key_data: got %h want %h", kif.data, exp_data); else pass_n++;
            end else begin
                step();
            end
        end
        tot_n++; if (!hit) $display("FAIL key_timeout: got no pulse want pulse for %h", {r, c}); else pass_n++;
        key_on = 1'b0;
        wait_ticks(8);
        tot_n++; if (pulses - p0 !== 1) $display("FAIL key_pulses: got %0d want 1", pulses - p0); else pass_n++;
    endtask

    task automatic test_digit_entry;
        int p0;
        do_reset();
        p0 = pulses;
        press_key(2'd0, 2'd1, 16'h0001);
        press_key(2'd0, 2'd2, 16'h0012);
        press_key(2'd0, 2'd3, 16'h0123);
        press_key(2'd1, 2'd0, 16'h1234);
        press_key(2'd1, 2'd1, 16'h2345);
        tot_n++; if (pulses - p0 !== 5) $display("FAIL entry_pulses: got %0d want 5", pulses - p0); else pass_n++;
    endtask

    task automatic test_bounce;
        int p0 = pulses;
        for (int n = 0; n < 64 && !(kif.row == 4'b1110 && tb_div == 0); n++) step();
        tot_n++;
        if (!(kif.row == 4'b1110 && tb_div == 0)) $display("FAIL bounce_align: got row %b want 1110", kif.row);
        else pass_n++;
        frc_en = 1'b1; frc_val = 4'b1110;
        wait_ticks(1);
        tot_n++; if (kif.row !== 4'b1110) $display("FAIL bounce_hold: got %b want 1110", kif.row); else pass_n++;
        frc_val = 4'b1111;
        wait_ticks(1);
        tot_n++; if (kif.row !== 4'b1110) $display("FAIL bounce_back: got %b want 1110", kif.row); else pass_n++;
        wait_ticks(1);
        tot_n++; if (kif.row !== 4'b1101) $display("FAIL bounce_scan: got %b want 1101", kif.row); else pass_n++;
        frc_en = 1'b0;
        tot_n++; if (pulses - p0 !== 0) $display("FAIL bounce_pulses: got %0d want 0", pulses - p0); else pass_n++;
        press_key(2'd0, 2'd0, 16'h3450);
    endtask

    task automatic test_two_cols;
        int p0 = pulses;
        int changes = 0;
        logic [3:0] prev;
        for (int n = 0; n < 8 && tb_div != 0; n++) step();
        dual_en = 1'b1;
        prev = kif.row;
        for (int i = 0; i < 20 * S; i++) begin
            step();
            if (kif.row != prev) changes++;
            prev = kif.row;
        end
        dual_en = 1'b0;
        tot_n++; if (changes !== 20) $display("FAIL dual_rotate: got %0d want 20", changes); else pass_n++;
        tot_n++; if (pulses - p0 !== 0) $display("FAIL dual_pulses: got %0d want 0", pulses - p0); else pass_n++;
        tot_n++; if (kif.data !== 16'h3450) $display("FAIL dual_data: got %h want 3450", kif.data); else pass_n++;
    endtask

    task automatic test_hold_f_reset;
        int det = -1;
        int hit = -1;
        int p0 = pulses;
        key_r = 2'd3; key_c = 2'd3; key_on = 1'b1;
        for (int n = 0; n < 200 && hit < 0; n++) begin
            if (det < 0 && tb_div == S - 1 && kif.row == 4'b0111) det = n;
            if (kif.key_valid === 1'b1) begin
                hit = n;
                tot_n++; if (kif.key_code !== 4'hF) $display("FAIL kf_code: got %h want F", kif.key_code); else pass_n++;
                tot_n++; if (kif.data !== 16'h450F) $display("FAIL kf_data: got %h want 450F", kif.data); else pass_n++;
            end else begin
                step();
            end
        end
        tot_n++; if (hit - det !== 9) $display("FAIL kf_latency: got %0d want 9", hit - det); else pass_n++;
        wait_ticks(1);
        key_on = 1'b0;
        wait_ticks(1);
        tot_n++; if (kif.row !== 4'b0111) $display("FAIL kf_rel1: got %b want 0111", kif.row); else pass_n++;
        key_on = 1'b1;
        wait_ticks(1);
        key_on = 1'b0;
        wait_ticks(2);
        tot_n++; if (kif.row !== 4'b0111) $display("FAIL kf_rel2: got %b want 0111", kif.row); else pass_n++;
        wait_ticks(1);
        tot_n++; if (kif.row !== 4'b1110) $display("FAIL kf_release: got %b want 1110", kif.row); else pass_n++;
        tot_n++; if (pulses - p0 !== 1) $display("FAIL kf_pulses: got %0d want 1", pulses - p0); else pass_n++;

        p0 = pulses;
        key_r = 2'd0; key_c = 2'd2; key_on = 1'b1;
        wait_ticks(1);
        tot_n++; if (kif.row !== 4'b1110) $display("FAIL rst_debounce_row: got %b want 1110", kif.row); else pass_n++;
        step();
        reset = 1'b1;
        step();
        tot_n++; if (kif.row !== 4'b1110) $display("FAIL rst_row: got %b want 1110", kif.row); else pass_n++;
        tot_n++; if (kif.data !== 16'h0000) $display("FAIL rst_data: got %h want 0000", kif.data); else pass_n++;
        tot_n++; if (kif.key_code !== 4'h0) $display("FAIL rst_code: got %h want 0", kif.key_code); else pass_n++;
        tot_n++; if (kif.key_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", kif.key_valid); else pass_n++;
        key_on = 1'b0;
        step();
        reset = 1'b0;
        repeat (40) step();
        tot_n++; if (pulses - p0 !== 0) $display("FAIL rst_pulses: got %0d want 0", pulses - p0); else pass_n++;
        tot_n++; if (kif.data !== 16'h0000) $display("FAIL rst_data_after: got %h want 0000", kif.data); else pass_n++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_hold_key9();
        test_digit_entry();
        test_bounce();
        test_two_cols();
        test_hold_f_reset();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule

// File: doc/hex_keypad_entry.md
# hex_keypad_entry

Input-side counterpart of the hex display path: scans a 4x4 matrix hex keypad, debounces presses and assembles the entered digits into a 16-bit value. The value is suitable for driving the display's `data` input. Row drive is time-multiplexed from a divided scan tick, mirroring the display's anode multiplexing. It sits between the board keypad pins and whatever logic consumes the entered value.

## Interface
- `SCAN_DIV`, 50000, clk cycles per scan tick (≥2).
- `DEBOUNCE_TICKS`, 8, consecutive identical tick samples required for press and for release (≥2).

- `clk`  in  1  system clock; all logic on rising edge; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `col`  in  4  keypad column sense, active-low (pulled up; low = key in driven row pressed).
- `row`  out  4  keypad row drive, active-low one-hot.
- `data`  out  16  entered value; newest digit in `data[3:0]`.
- `key_code`  out  4  code of last accepted key.
- `key_valid`  out  1  one-cycle pulse per accepted key.

## Operation
- Tick divider: counter 0..`SCAN_DIV`-1; `tick` is high in the cycle the counter equals `SCAN_DIV`-1 and wraps to 0.
- `col` is sampled only in tick cycles. `row` changes only on the edge ending a tick cycle. Each row therefore has `SCAN_DIV`-1 settle cycles.
- Valid sample: exactly one `col` bit low. Let its index be `c` and the driven row index be `r`. Key code = `{r[1:0], c[1:0]}` (r*4+c).
- All-high means no key. Two or more low bits are invalid and handled like no key.
- FSM states:
  - SCAN:
    - On tick with a valid sample: latch `r`, `c` and the `col` pattern; set the debounce count to 1; go to DEBOUNCE. `row` holds.
    - Otherwise `row` rotates 0→1→2→3→0 (1110→1101→1011→0111→1110).
  - DEBOUNCE:
    - On tick with `col` equal to the latched pattern: increment the count.
    - When the count reaches `DEBOUNCE_TICKS`: accept the key and go to HELD.
    - On tick with any other pattern: go to SCAN with no row advance. The same row is re-evaluated on the next tick.
  - HELD:
    - On tick with `col` all-high: increment the release count. Any other pattern clears the release count.
    - When the release count reaches `DEBOUNCE_TICKS`: go to SCAN. `row` advances on that edge.
    - Other keys pressed while HELD are ignored; there is no rollover.
- Accept: `data` ← `{data[11:0], code}`; the old top nibble is discarded. `key_code` ← code. `key_valid` = 1 for one cycle.

## Timing
- Reset values: `row`=4'b1110, `data`=16'h0000, `key_code`=4'h0, `key_valid`=0. FSM=SCAN, divider=0, all counts=0.
- Reset asserted mid-operation restores these values on the next edge. A pending key is discarded and no `key_valid` is emitted.
- `key_valid`, `data` and `key_code` update together on the edge ending the accepting tick cycle.
- Latency from the first detecting tick to `key_valid` high = (`DEBOUNCE_TICKS`-1)*`SCAN_DIV` + 1 clk cycles, plus synchronizer delay if enabled.
- Minimum spacing between two `key_valid` pulses is 2*`DEBOUNCE_TICKS`*`SCAN_DIV` cycles.
- Outputs are registered; no combinational path from `col` to any output.

## Configuration
- `KEYPAD_SYNC_EN` defined:
  - `col` passes through a 2-flop synchronizer, reset to 4'b1111, before sampling.
  - Sampling in a tick cycle uses the synchronized value.
  - Press latency grows by 2 cycles; the effective settle time is `SCAN_DIV`-3 cycles.
- Undefined: `col` is sampled directly. The caller guarantees the input is synchronous.

## Test plan
Parameters: `SCAN_DIV`=4, `DEBOUNCE_TICKS`=3, macro undefined.
- Idle after reset, `col`=1111 for 40 cycles:
  - `row` cycles 1110,1101,1011,0111 every 4 cycles.
  - `key_valid` never high; `data`=0000.
- Hold key r=2, c=1 (`col`=1101 whenever `row`=1011) until accepted:
  - One `key_valid` pulse 9 cycles after the detecting tick.
  - `key_code`=9; `data`=0009.
  - `row` stays 1011 until release.
- Enter keys 1, 2, 3, 4, 5 with full release between:
  - `data` sequence 0001, 0012, 0123, 1234, 2345.
  - Exactly 5 pulses.
- Bounce: key r=0, c=0 low for 1 tick, high for 1 tick:
  - Returns to SCAN on row 0; no `key_valid`.
  - A subsequent stable press yields `key_code`=0.
- Two columns low (`col`=1100) on row 1 for 20 ticks: no acceptance; scanning continues.
- Hold key F:
  - Pulse after 2 ticks (`key_valid`).
  - Release after 1 tick, re-press, release for 3 ticks:
    - Only one pulse during the held interval.
    - `reset` asserted in DEBOUNCE of the next press gives the reset values and no pulse.
